// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for logic_unit_pipe: request side (in_*) and response side (out_*).
// Optional popcount op selected in the block by macro LOGIC_UNIT_POPCNT_EN.
//
// Valid/ready semantics: a beat transfers on a rising clk edge where valid && ready.
// A producer holding valid keeps its payload stable until the transfer. ready may
// depend combinationally on the consumer's downstream ready, but never on valid.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_parity;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_zero, out_parity
    );

    // The logic unit itself.
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_zero, out_parity
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with tag passthrough and
// zero/parity flags. S1 holds the accepted operands, S2 holds the registered result.
// Macro LOGIC_UNIT_POPCNT_EN: when defined, op 111 returns popcount(A); otherwise
// op 111 passes A through unchanged and no counting logic exists.
module logic_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input logic              clk,
    input logic              reset,
    logic_unit_pipe_if.slave bus
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;

`ifdef LOGIC_UNIT_POPCNT_EN
    // Count never exceeds WIDTH, so the upper result bits stay zero.
    function automatic logic [WIDTH-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{(WIDTH-1){1'b0}}, v[i]};
        end
        return c;
    endfunction
`endif

    // Stage 1: accepted operands.
    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    // Stage 2: result and flags presented downstream.
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_parity_q, s2_parity_d;

    logic             s2_free;
    logic             s1_adv;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] s1_result;

    // Handshake control: in_ready looks only at pipeline state and out_ready.
    always_comb begin
        s2_free  = !s2_valid_q || bus.out_ready;
        s1_adv   = s1_valid_q && s2_free;
        in_ready = !s1_valid_q || s1_adv;
        accept   = bus.in_valid && in_ready;
    end

    // Op decode on the S1 operands.
    always_comb begin
        s1_result = '0;
        unique case (s1_op_q)
            OP_AND:  s1_result = s1_a_q & s1_b_q;
            OP_OR:   s1_result = s1_a_q | s1_b_q;
            OP_XOR:  s1_result = s1_a_q ^ s1_b_q;
            OP_NOR:  s1_result = ~(s1_a_q | s1_b_q);
            OP_ANDN: s1_result = s1_a_q & ~s1_b_q;
            OP_ORN:  s1_result = s1_a_q | ~s1_b_q;
            OP_XNOR: s1_result = ~(s1_a_q ^ s1_b_q);
            default: begin
`ifdef LOGIC_UNIT_POPCNT_EN
                s1_result = popcnt(s1_a_q);
`else
                s1_result = s1_a_q;
`endif
            end
        endcase
    end

    // Next-state for both stages; payload registers only load on a transfer.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = bus.in_op;
            s1_a_d     = bus.in_a;
            s1_b_d     = bus.in_b;
            s1_tag_d   = bus.in_tag;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;
        s2_zero_d   = s2_zero_q;
        s2_parity_d = s2_parity_q;
        if (s1_adv) begin
            s2_valid_d  = 1'b1;
            s2_result_d = s1_result;
            s2_tag_d    = s1_tag_q;
            s2_zero_d   = (s1_result == '0);
            s2_parity_d = ^s1_result;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset drops in-flight ops and clears the output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_tag_q    <= '0;
            s2_zero_q   <= 1'b0;
            s2_parity_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
            s2_zero_q   <= s2_zero_d;
            s2_parity_q <= s2_parity_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_tag    = s2_tag_q;
    assign bus.out_zero   = s2_zero_q;
    assign bus.out_parity = s2_parity_q;

endmodule
